// File: rtl/apb_timer_pkg.sv
// Register map, CTRL layout and address helper for apb_timer.
// Pure declarations; no logic, no latency, no flow control.
package apb_timer_pkg;

  localparam logic [4:0] TMR_CTRL_OFS     = 5'h00;
  localparam logic [4:0] TMR_LOAD_OFS     = 5'h04;
  localparam logic [4:0] TMR_VALUE_OFS    = 5'h08;
  localparam logic [4:0] TMR_STATUS_OFS   = 5'h0C;
  localparam logic [4:0] TMR_PRESCALE_OFS = 5'h10;

  localparam int CTRL_EN_BIT          = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } tmr_ctrl_t;

  // Only Paddr[4:2] is decoded; rebuild a byte offset for comparison with the map.
  function automatic logic [4:0] tmr_ofs(input logic [2:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// Tick divider: one-cycle tick every prescale+1 clocks while en; counter held at 0 when idle.
// New prescale values are sampled only at a wrap (or while idle); no backpressure.
module apb_timer_prescaler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] lim_q, lim_d;
  logic       wrap;

  assign wrap = (cnt_q == lim_q);
  assign tick = en & wrap;

  always_comb begin
    cnt_d = cnt_q;
    lim_d = lim_q;
    if (!en || wrap) begin
      cnt_d = '0;
      lim_d = prescale;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// Zero-wait APB down-counter timer with auto-reload, sticky EXPIRED and level irq; writes commit in the access phase, reads are combinational.
// Optional prescaler enabled by `APB_TIMER_PRESCALER_EN; no PREADY, so the bus is never stalled.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        Hclk,
  input  logic        Hrstn,
  input  logic        Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        timer_irq
);

  logic             wr_en, rd_en;
  logic [4:0]       ofs;
  logic             ctrl_wr, load_wr, status_wr;
  logic             tick, tick_en, expire_evt;
  logic [31:0]      rdata;
  logic             unused_bits;

  tmr_ctrl_t        ctrl_q, ctrl_d;
  logic [CNT_W-1:0] load_q, load_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic             expired_q, expired_d;

  assign wr_en     = Pselx & Penable & Pwrite;
  assign rd_en     = Pselx & ~Pwrite;
  assign ofs       = tmr_ofs(Paddr[4:2]);
  assign ctrl_wr   = wr_en & (ofs == TMR_CTRL_OFS);
  assign load_wr   = wr_en & (ofs == TMR_LOAD_OFS);
  assign status_wr = wr_en & (ofs == TMR_STATUS_OFS);

  assign unused_bits = ^{Paddr[31:5], Paddr[1:0], Pwdata};

`ifdef APB_TIMER_PRESCALER_EN
  logic [7:0] prescale_q, prescale_d;

  always_comb begin
    prescale_d = prescale_q;
    if (wr_en && (ofs == TMR_PRESCALE_OFS)) prescale_d = Pwdata[7:0];
  end

  always_ff @(posedge Hclk or negedge Hrstn) begin
    if (!Hrstn) prescale_q <= '0;
    else        prescale_q <= prescale_d;
  end

  apb_timer_prescaler u_prescaler (
    .clk      (Hclk),
    .rst_n    (Hrstn),
    .en       (ctrl_q.en),
    .prescale (prescale_q),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // A CTRL write that clears EN cancels the tick on its edge entirely.
  assign tick_en    = ctrl_q.en & tick & ~(ctrl_wr & ~Pwdata[CTRL_EN_BIT]);
  assign expire_evt = tick_en & (value_q == '0);

  always_comb begin
    ctrl_d = ctrl_q;
    load_d = load_q;
    value_d = value_q;
    if (tick_en) begin
      if (!expire_evt)             value_d = value_q - CNT_W'(1);
      else if (ctrl_q.auto_reload) value_d = load_q;
      else                         ctrl_d.en = 1'b0;
    end
    // Bus writes are applied last so they override the counting update.
    if (ctrl_wr) begin
      ctrl_d.en          = Pwdata[CTRL_EN_BIT];
      ctrl_d.auto_reload = Pwdata[CTRL_AUTO_RELOAD_BIT];
      ctrl_d.irq_en      = Pwdata[CTRL_IRQ_EN_BIT];
    end
    if (load_wr) begin
      load_d  = Pwdata[CNT_W-1:0];
      value_d = Pwdata[CNT_W-1:0];
    end
    expired_d = (expired_q & ~(status_wr & Pwdata[0])) | expire_evt;
  end

  always_ff @(posedge Hclk or negedge Hrstn) begin
    if (!Hrstn) begin
      ctrl_q    <= '0;
      load_q    <= '0;
      value_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      expired_q <= expired_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      TMR_CTRL_OFS:     rdata = {29'b0, ctrl_q};
      TMR_LOAD_OFS:     rdata = 32'(load_q);
      TMR_VALUE_OFS:    rdata = 32'(value_q);
      TMR_STATUS_OFS:   rdata = {31'b0, expired_q};
`ifdef APB_TIMER_PRESCALER_EN
      TMR_PRESCALE_OFS: rdata = {24'b0, prescale_q};
`endif
      default:          rdata = '0;
    endcase
  end

  assign Prdata    = rd_en ? rdata : 32'h0;
  assign timer_irq = expired_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed table, multi-cycle corner sequences and a random run
// checked against an elapsed-time reference model.
module tb_apb_timer;

  logic        Hclk = 1'b0;
  logic        Hrstn = 1'b0;
  logic        Pselx = 1'b0;
  logic        Penable = 1'b0;
  logic        Pwrite = 1'b0;
  logic [31:0] Paddr = '0;
  logic [31:0] Pwdata = '0;
  logic [31:0] Prdata;
  logic        timer_irq;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  apb_timer dut (
    .Hclk      (Hclk),
    .Hrstn     (Hrstn),
    .Pselx     (Pselx),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata),
    .timer_irq (timer_irq)
  );

  always #5 Hclk = ~Hclk;
  always @(posedge Hclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic bus_idle();
    Pselx = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
  endtask

  // Called at a negedge after edge e; commits on edge e+2, returns at the negedge after it.
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
    @(negedge Hclk);
    Penable = 1'b1;
    @(negedge Hclk);
    bus_idle();
  endtask

  // Samples in the setup phase, i.e. the state left by the most recent edge.
  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic irq);
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = a;
    #1;
    d = Prdata;
    irq = timer_irq;
    @(negedge Hclk);
    Penable = 1'b1;
    @(negedge Hclk);
    bus_idle();
  endtask

  task automatic do_reset();
    bus_idle();
    Hrstn = 1'b0;
    repeat (3) @(negedge Hclk);
    Hrstn = 1'b1;
    @(negedge Hclk);
  endtask

  // Reference model: a snapshot taken at the last write edge plus elapsed clocks.
  logic [31:0] m_v0, m_load;
  bit          m_en, m_ar, m_ie, m_exp;
  int          m_c0;

  function automatic void pred(input int c, output bit en, output logic [31:0] val, output bit ex);
    longint k, j;
    k = longint'(c - m_c0);
    en = m_en; val = m_v0; ex = m_exp;
    if (m_en && k > 0) begin
      if (k <= longint'(m_v0)) begin
        val = m_v0 - 32'(k);
      end else begin
        ex = 1'b1;
        if (m_ar) begin
          j = (k - longint'(m_v0) - 1) % (longint'(m_load) + 1);
          val = m_load - 32'(j);
        end else begin
          val = '0;
          en = 1'b0;
        end
      end
    end
  endfunction

  function automatic void model_write(input int c, input logic [31:0] a, input logic [31:0] d);
    bit en, ex, en1, ex1;
    logic [31:0] val, val1;
    pred(c, en, val, ex);
    pred(c - 1, en1, val1, ex1);
    case (a[4:2])
      3'd0: begin
        if (!d[0]) begin val = val1; ex = ex1; end
        en = d[0]; m_ar = d[1]; m_ie = d[2];
      end
      3'd1: begin m_load = d; val = d; end
      3'd3: if (d[0]) ex = en1 && (val1 == 0);
      default: ;
    endcase
    m_c0 = c; m_v0 = val; m_en = en; m_exp = ex;
  endfunction

  function automatic logic [31:0] model_read(input int c, input logic [2:0] idx, output logic irq);
    bit en, ex;
    logic [31:0] val, r;
    pred(c, en, val, ex);
    irq = ex & m_ie;
    case (idx)
      3'd0: r = {29'b0, m_ie, m_ar, en};
      3'd1: r = m_load;
      3'd2: r = val;
      3'd3: r = {31'b0, ex};
      default: r = '0;
    endcase
    return r;
  endfunction

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        tbl[21];
    logic [31:0] rd_d;
    logic        rd_irq, m_irq;
    logic [31:0] a, d, e;
    int          wi[7];

    tbl[0]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0000_0008, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_000C, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0000_0010, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0000_001C, 32'h0, 32'h0};
    tbl[6]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF6, 32'h0};
    tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h6};
    tbl[8]  = '{1'b1, 32'h0000_0004, 32'h1234, 32'h0};
    tbl[9]  = '{1'b0, 32'h0000_0004, 32'h0, 32'h1234};
    tbl[10] = '{1'b0, 32'h0000_0008, 32'h0, 32'h1234};
    tbl[11] = '{1'b1, 32'h0000_0008, 32'h55, 32'h0};
    tbl[12] = '{1'b0, 32'h0000_0008, 32'h0, 32'h1234};
    tbl[13] = '{1'b1, 32'h0000_0018, 32'hFFFF, 32'h0};
    tbl[14] = '{1'b0, 32'h0000_0018, 32'h0, 32'h0};
    tbl[15] = '{1'b0, 32'hABCD_0024, 32'h0, 32'h1234};
    tbl[16] = '{1'b0, 32'h0000_0003, 32'h0, 32'h6};
    tbl[17] = '{1'b1, 32'h0000_000C, 32'h1, 32'h0};
    tbl[18] = '{1'b0, 32'h0000_000C, 32'h0, 32'h0};
    tbl[19] = '{1'b1, 32'h0000_0000, 32'h0, 32'h0};
    tbl[20] = '{1'b0, 32'h0000_0000, 32'h0, 32'h0};
    wi = '{0, 1, 2, 3, 5, 6, 7};

    do_reset();
    for (int i = 0; i < 21; i++) begin
      if (tbl[i].wr) apb_wr(tbl[i].addr, tbl[i].data);
      else begin
        apb_rd(tbl[i].addr, rd_d, rd_irq);
        chk($sformatf("table%0d_rdata", i), rd_d, tbl[i].exp);
        chk($sformatf("table%0d_irq", i), {31'b0, rd_irq}, 32'h0);
      end
    end

    // One-shot: LOAD=5, irq exactly 6 clocks after the CTRL commit.
    apb_wr(32'h4, 32'd5);
    apb_wr(32'h0, 32'h5);
    for (int i = 1; i <= 6; i++) begin
      @(negedge Hclk);
      if (i == 5) chk("oneshot_irq_early", {31'b0, timer_irq}, 32'h0);
      if (i == 6) chk("oneshot_irq_on_time", {31'b0, timer_irq}, 32'h1);
    end
    apb_rd(32'h8, rd_d, rd_irq); chk("oneshot_value", rd_d, 32'h0);
    apb_rd(32'h0, rd_d, rd_irq); chk("oneshot_ctrl", rd_d, 32'h4);
    apb_rd(32'hC, rd_d, rd_irq); chk("oneshot_status", rd_d, 32'h1);
    apb_wr(32'hC, 32'h1);
    apb_rd(32'hC, rd_d, rd_irq); chk("oneshot_clear", rd_d, 32'h0);
    chk("oneshot_clear_irq", {31'b0, rd_irq}, 32'h0);

    // Auto-reload: VALUE 3,2,1,0,3,... sampled every clock by back-to-back reads.
    apb_wr(32'h4, 32'd3);
    apb_wr(32'h0, 32'h3);
    Pselx = 1'b1; Pwrite = 1'b0; Penable = 1'b0; Paddr = 32'h8;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(negedge Hclk); Penable = ~Penable; end
      #1 chk($sformatf("reload_value%0d", i), Prdata, 32'(3 - (i % 4)));
    end
    bus_idle();
    apb_wr(32'h0, 32'h0);
    apb_wr(32'hC, 32'h1);
    apb_wr(32'h0, 32'h3);
    Pselx = 1'b1; Pwrite = 1'b0; Penable = 1'b0; Paddr = 32'hC;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge Hclk); Penable = ~Penable; end
      #1 chk($sformatf("reload_status%0d", i), Prdata, (i >= 4) ? 32'h1 : 32'h0);
    end
    bus_idle();
    apb_wr(32'h0, 32'h0);
    apb_wr(32'hC, 32'h1);

    // W1C landing on an expiry edge must leave EXPIRED set.
    apb_wr(32'h4, 32'd3);
    apb_wr(32'h0, 32'h7);
    repeat (6) @(negedge Hclk);
    apb_wr(32'hC, 32'h1);
    apb_rd(32'hC, rd_d, rd_irq);
    chk("collide_status", rd_d, 32'h1);
    chk("collide_irq", {31'b0, rd_irq}, 32'h1);
    apb_wr(32'h0, 32'h0);
    apb_wr(32'hC, 32'h1);
    apb_rd(32'hC, rd_d, rd_irq);
    chk("collide_cleared", rd_d, 32'h0);
    chk("collide_cleared_irq", {31'b0, rd_irq}, 32'h0);

    // LOAD write while VALUE=7: new value wins; later VALUE write ignored.
    apb_wr(32'h4, 32'h40);
    apb_wr(32'h0, 32'h1);
    repeat (56) @(negedge Hclk);
    apb_wr(32'h4, 32'h20);
    apb_rd(32'h8, rd_d, rd_irq); chk("loadtick_value", rd_d, 32'h20);
    apb_wr(32'h8, 32'h99);
    apb_rd(32'h8, rd_d, rd_irq); chk("value_write_ignored", rd_d, 32'h1C);
    apb_wr(32'h0, 32'h0);

    // Random traffic against the reference model.
    do_reset();
    m_v0 = '0; m_load = '0; m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_c0 = cyc;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = ($urandom & 32'hFFFF_FFE3) | (32'(wi[$urandom_range(0, 6)]) << 2);
        d = $urandom;
        if (a[4:2] == 3'd1) d = 32'($urandom_range(0, 9));
        model_write(cyc + 2, a, d);
        apb_wr(a, d);
      end else begin
        a = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
        e = model_read(cyc, a[4:2], m_irq);
        apb_rd(a, rd_d, rd_irq);
        chk($sformatf("rand%0d_rdata@%02h", n, a[4:0]), rd_d, e);
        chk($sformatf("rand%0d_irq", n), {31'b0, rd_irq}, {31'b0, m_irq});
      end
      repeat ($urandom_range(0, 3)) @(negedge Hclk);
    end

`ifdef APB_TIMER_PRESCALER_EN
    do_reset();
    apb_wr(32'h10, 32'd3);
    apb_wr(32'h4, 32'd2);
    apb_wr(32'h0, 32'h5);
    for (int i = 1; i <= 12; i++) begin
      @(negedge Hclk);
      if (i == 11) chk("presc_irq_early", {31'b0, timer_irq}, 32'h0);
      if (i == 12) chk("presc_irq_on_time", {31'b0, timer_irq}, 32'h1);
    end
    apb_rd(32'h10, rd_d, rd_irq); chk("presc_readback", rd_d, 32'h3);
`endif

    // Asynchronous reset in the middle of a count.
    do_reset();
    apb_wr(32'h4, 32'd100);
    apb_wr(32'h0, 32'h1);
    repeat (10) @(negedge Hclk);
    Pselx = 1'b1; Pwrite = 1'b0; Penable = 1'b0; Paddr = 32'h8;
    #1 chk("midreset_pre_value", Prdata, 32'd90);
    #2 Hrstn = 1'b0;
    #1 chk("midreset_async_value", Prdata, 32'h0);
    bus_idle();
    @(negedge Hclk);
    @(negedge Hclk);
    Hrstn = 1'b1;
    repeat (20) @(negedge Hclk);
    apb_rd(32'h8, rd_d, rd_irq); chk("midreset_value_idle", rd_d, 32'h0);
    apb_rd(32'h0, rd_d, rd_irq); chk("midreset_ctrl", rd_d, 32'h0);
    apb_rd(32'h4, rd_d, rd_irq); chk("midreset_load", rd_d, 32'h0);
    apb_rd(32'hC, rd_d, rd_irq); chk("midreset_status", rd_d, 32'h0);
    apb_rd(32'h10, rd_d, rd_irq); chk("midreset_prescale", rd_d, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_timer.md
# apb_timer

Zero-wait-state APB timer peripheral that sits directly downstream of the AHB-to-APB bridge FSM. It consumes the bridge's APB request (`Pselx`, `Penable`, `Pwrite`, `Paddr`, `Pwdata`) and returns `Prdata`, which the bridge forwards to `Hrdata`. It provides a programmable down-counter with optional auto-reload, a sticky expiry flag and an interrupt output. The bridge has no `PREADY` or `PSLVERR` input, so every access completes in its access phase with no error signalling.

## Interface
- `CNT_W`, 32, counter and LOAD width (1..32). Reads are zero-extended; `Pwdata` bits above `CNT_W` are ignored.
- `Hclk`  in  1  single clock; rising edge active.
- `Hrstn`  in  1  asynchronous, active-low reset.
- `Pselx`  in  1  slave select from the bridge.
- `Penable`  in  1  access phase.
- `Pwrite`  in  1  1 = write, 0 = read.
- `Paddr`  in  32  byte address. Only `Paddr[4:2]` is decoded; the other bits are ignored.
- `Pwdata`  in  32  write data.
- `Prdata`  out  32  read data (combinational).
- `timer_irq`  out  1  level interrupt, equal to `STATUS.EXPIRED & CTRL.IRQ_EN`.

## Operation
- **Register map (byte offsets):**
  - 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Other bits read 0.
  - 0x04 LOAD: R/W.
  - 0x08 VALUE: read-only; writes are ignored.
  - 0x0C STATUS: bit0 EXPIRED; write 1 to clear.
  - 0x10 PRESCALE: bits[7:0]. Present only with the macro (see Configuration).
  - Unmapped offsets read 0; writes to them are ignored.
- **Write commit:** on the `Hclk` edge where `Pselx & Penable & Pwrite` is 1. Exactly one commit per transfer.
- **Read data:** `Prdata` = the decoded register whenever `Pselx & !Pwrite`, otherwise 0. This is valid in both the setup and access phases.
- **Writing LOAD:** updates LOAD and VALUE on the same edge.
- **Counting:** when EN = 1, on each tick:
  - VALUE ≠ 0: VALUE ← VALUE − 1.
  - VALUE = 0: EXPIRED ← 1, then:
    - AUTO_RELOAD = 1: VALUE ← LOAD.
    - AUTO_RELOAD = 0: EN ← 0 and VALUE holds 0.
- **Tick rate:** every clock without the prescaler; see Configuration otherwise.
- **Simultaneous events:**
  - LOAD write and tick on the same edge: the written value wins, with no decrement.
  - STATUS W1C and expiry on the same edge: the flag stays set.
  - CTRL write clearing EN and tick on the same edge: no decrement.
  - One-shot expiry and a CTRL write on the same edge: the CTRL write wins.

## Timing
- **Reset values:** CTRL, LOAD, VALUE, STATUS and PRESCALE = 0; `timer_irq` = 0; `Prdata` = 0.
- **Reset mid-count:** takes effect immediately and asynchronously. The timer stays idle until reprogrammed.
- **Expiry latency:** with LOAD = L and no prescale, EXPIRED rises L+1 clocks after the EN write edge.
- **Interrupt latency:** `timer_irq` rises on the same edge as EXPIRED (registered source) and follows an IRQ_EN write on the commit edge.
- **Auto-reload period:** L+1 ticks.
- **Bus timing:** every access takes 2 `Hclk` cycles (setup + access), zero wait states. The bridge needs 2 extra cycles after a write before it can issue the next transfer.

## Configuration
- **Macro:** `APB_TIMER_PRESCALER_EN`.
- **Defined:**
  - An 8-bit PRESCALE register exists at 0x10.
  - A tick occurs once every PRESCALE+1 clocks.
  - The prescale counter is held at 0 while EN = 0 and restarts when EN is set.
  - Writing PRESCALE while running takes effect at the next prescale-counter wrap.
- **Undefined:**
  - Ticks occur every clock.
  - Offset 0x10 reads 0 and ignores writes.
  - No prescale logic is synthesised.

## Structure
- **Package `apb_timer_pkg`:**
  - Register offset constants: `TMR_CTRL_OFS`, `TMR_LOAD_OFS`, `TMR_VALUE_OFS`, `TMR_STATUS_OFS`, `TMR_PRESCALE_OFS`.
  - CTRL bit indices.
  - A packed CTRL register typedef.
- **Sub-module `apb_timer_prescaler`:** 8-bit counter producing a one-cycle `tick` pulse.
  - Instantiated only under the macro.
  - Otherwise `tick` is tied to 1.

## Test plan
- **Reset defaults:** assert `Hrstn` = 0 for 3 cycles, then read all offsets → all 0, `timer_irq` = 0.
- **One-shot expiry:**
  - Write LOAD = 5, then CTRL = 0x5 → EXPIRED and `timer_irq` = 1 exactly 6 clocks after the CTRL commit.
  - Afterwards VALUE = 0 and CTRL reads 0x4 (EN auto-cleared).
- **Auto-reload:** write LOAD = 3, CTRL = 0x3 → VALUE sequence 3,2,1,0,3,2…; EXPIRED first sets 4 clocks after the CTRL commit.
- **Clear/expiry collision:** write STATUS = 1 on the same edge VALUE hits 0 → EXPIRED remains 1. A subsequent write STATUS = 1 → EXPIRED = 0, `timer_irq` = 0.
- **Load/tick collision:** write LOAD = 0x20 while running with VALUE = 7 → next VALUE read = 0x20, not 6. A write to VALUE is ignored.
- **Prescaler (macro defined):** PRESCALE = 3, LOAD = 2, EN = 1 → expiry after 12 clocks. Assert `Hrstn` low mid-count → all registers read 0 and no further ticks.
